// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, FETCH, DATA)
//   FUNCT3_WORD : access-size code for a 32-bit word, used for every fetch
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a load/store
// data port share one single-outstanding memory port.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   if_req/if_addr           : fetch request (held until if_valid)
//   if_rdata/if_valid        : fetched word, one-cycle completion pulse
//   if_stall                 : fetch pending (if_req & ~if_valid)
//   d_req/d_we/d_addr/
//   d_wdata/d_funct3         : data request (held until d_valid)
//   d_rdata/d_valid          : load result, one-cycle completion pulse
//   d_stall                  : data pending (d_req & ~d_valid)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_funct3     : memory-side request, stable until mem_ack
//   mem_rdata/mem_ack        : memory read data, one-cycle completion pulse
//   busy                     : FSM not in IDLE
//   dbg_state                : current FSM state
//
// Handshake: a requester raises req with its fields and keeps req high until
// it sees its own valid pulse. The arbiter latches the fields on the grant
// edge, so requester inputs may change freely afterwards. The memory sees
// mem_req high with stable fields until it returns a single mem_ack pulse;
// the matching valid pulses on the cycle after mem_ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output arb_state_t        dbg_state
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;

    logic if_elig;
    logic d_elig;
    logic starved;
    logic grant_d;
    logic grant_if;
    logic ack_fetch;
    logic ack_data;

    // A requester whose valid is high this cycle is still holding req from
    // the access that just finished; it must not be granted again yet.
    assign if_elig = if_req & ~if_valid;
    assign d_elig  = d_req & ~d_valid;
    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data normally wins; fetch wins only once it has been passed over
    // STARVE_MAX times in a row.
    assign grant_d  = (state == IDLE) & d_elig & (~if_elig | ~starved);
    assign grant_if = (state == IDLE) & if_elig & ~grant_d;

    assign ack_fetch = (state == FETCH) & mem_ack;
    assign ack_data  = (state == DATA) & mem_ack;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = DATA;
                end else if (grant_if) begin
                    state_next = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state    <= state_next;
            if_valid <= ack_fetch;
            d_valid  <= ack_data;
            if (ack_fetch) begin
                if_rdata <= mem_rdata;
            end
            if (ack_data) begin
                d_rdata <= mem_rdata;
            end
            if (grant_d) begin
                lat_addr   <= d_addr;
                lat_we     <= d_we;
                lat_wdata  <= d_wdata;
                lat_funct3 <= d_funct3;
                // Only grants that actually made fetch wait count towards
                // starvation; the counter saturates at STARVE_MAX.
                if (if_req && !starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_if) begin
                lat_addr   <= if_addr;
                lat_we     <= 1'b0;
                lat_funct3 <= FUNCT3_WORD;
                starve_cnt <= '0;
            end
        end
    end

    assign mem_req    = (state != IDLE);
    assign mem_we     = mem_req & lat_we;
    assign mem_addr   = lat_addr;
    assign mem_wdata  = lat_wdata;
    assign mem_funct3 = lat_funct3;
    assign busy       = mem_req;
    assign if_stall   = if_req & ~if_valid;
    assign d_stall    = d_req & ~d_valid;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, every cycle compared against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W     = 8;
    localparam int STARVE_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic [2:0]        d_funct3 = '0;
    logic [31:0]       d_rdata;
    logic              d_valid;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              busy;
    arb_state_t        dbg_state;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_rdata(d_rdata), .d_valid(d_valid),
        .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = no access in flight, 1 = fetch, 2 = data
    int                owner = 0;
    int                starve = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_we = 1'b0;
    logic [31:0]       m_wdata = '0;
    logic [2:0]        m_funct3 = '0;
    logic              m_ifv = 1'b0;
    logic              m_dv = 1'b0;
    logic [31:0]       m_if_rd = '0;
    logic [31:0]       m_d_rd = '0;
    bit                m_d_rd_known = 1'b1;
    logic [31:0]       exp_q[$];          // fetched words awaiting if_valid
    logic [ADDR_W:0]   grant_log[$];      // {we, addr} of each observed grant

    // Effect of one rising edge, from the inputs present at that edge.
    task automatic model_step();
        bit f_el;
        bit d_el;
        bit nifv;
        bit ndv;
        nifv = 1'b0;
        ndv  = 1'b0;
        if (rst) begin
            owner = 0; starve = 0;
            m_ifv = 1'b0; m_dv = 1'b0;
            m_if_rd = '0; m_d_rd = '0; m_d_rd_known = 1'b1;
            exp_q.delete();
        end else begin
            if (owner == 0) begin
                f_el = if_req && !m_ifv;
                d_el = d_req && !m_dv;
                if (d_el && (!f_el || starve < STARVE_MAX)) begin
                    owner = 2;
                    m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_funct3 = d_funct3;
                    if (if_req) starve = (starve >= STARVE_MAX) ? STARVE_MAX : starve + 1;
                end else if (f_el) begin
                    owner = 1;
                    m_addr = if_addr; m_we = 1'b0; m_funct3 = 3'b010;
                    starve = 0;
                end
            end else if (mem_ack) begin
                if (owner == 1) begin
                    nifv = 1'b1;
                    m_if_rd = mem_rdata;
                    exp_q.push_back(mem_rdata);
                end else begin
                    ndv = 1'b1;
                    m_d_rd = mem_rdata;
                    m_d_rd_known = !m_we;
                end
                owner = 0;
            end
            m_ifv = nifv;
            m_dv  = ndv;
        end
    endtask

    task automatic check_outputs();
        arb_state_t es;
        bit act;
        act = (owner != 0);
        es = (owner == 0) ? IDLE : ((owner == 1) ? FETCH : DATA);
        check("mem_req", 32'(mem_req), 32'(act));
        check("busy", 32'(busy), 32'(act));
        check("state", 32'(dbg_state), 32'(es));
        if (act) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_funct3", 32'(mem_funct3), 32'(m_funct3));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
        end
        check("if_valid", 32'(if_valid), 32'(m_ifv));
        check("d_valid", 32'(d_valid), 32'(m_dv));
        check("if_rdata", if_rdata, m_if_rd);
        if (m_d_rd_known) check("d_rdata", d_rdata, m_d_rd);
        check("if_stall", 32'(if_stall), 32'(if_req & ~m_ifv));
        check("d_stall", 32'(d_stall), 32'(d_req & ~m_dv));
        if (if_valid) begin
            check("if_q_size", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) check("if_valid_data", if_rdata, exp_q.pop_front());
        end
    endtask

    // ---------------- memory responder ----------------
    int ack_delay = 0;
    int ack_cnt = 0;
    bit rand_delay = 1'b0;
    bit spurious = 1'b0;
    bit prev_req = 1'b0;

    // One clock: model the edge, check at the falling edge, then drive the
    // memory side for the next edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (mem_req && !prev_req) grant_log.push_back({mem_we, mem_addr});
        prev_req = mem_req;
        mem_rdata = $urandom();
        if (mem_req) begin
            mem_ack = (ack_cnt == ack_delay);
            ack_cnt = mem_ack ? 0 : ack_cnt + 1;
            if (mem_ack && rand_delay) ack_delay = $urandom_range(0, 3);
        end else begin
            ack_cnt = 0;
            mem_ack = spurious && ($urandom_range(0, 7) == 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input bit fetch, input int max, output int lat);
        lat = 0;
        for (int i = 0; i < max; i++) begin
            cycle();
            lat++;
            if (fetch ? if_valid : d_valid) break;
        end
        if (fetch) check("if_valid_seen", 32'(if_valid), 32'd1);
        else       check("d_valid_seen", 32'(d_valid), 32'd1);
    endtask

    task automatic scramble_d();
        d_we = 1'($urandom_range(0, 1));
        d_addr = ADDR_W'($urandom());
        d_wdata = $urandom();
        d_funct3 = 3'($urandom_range(0, 7));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [ADDR_W:0] exp_g;

        do_reset();
        cycle();

        // Single fetch, immediate ack.
        grant_log.delete();
        ack_delay = 0;
        if_req = 1'b1; if_addr = 8'h04;
        wait_valid(1'b1, 20, lat);
        check("fetch_latency", 32'(lat), 32'd2);
        check("fetch_grant", 32'(grant_log.size() > 0 ? grant_log[0] : '1), {23'd0, 1'b0, 8'h04});
        if_req = 1'b0;
        cycle();

        // Simultaneous requests: the store goes first.
        grant_log.delete();
        if_req = 1'b1; if_addr = 8'h08;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        wait_valid(1'b0, 20, lat);
        d_req = 1'b0;
        wait_valid(1'b1, 20, lat);
        if_req = 1'b0;
        cycle();
        check("sim_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("sim_first", 32'(grant_log[0]), {23'd0, 1'b1, 8'h10});
            check("sim_second", 32'(grant_log[1]), {23'd0, 1'b0, 8'h08});
        end

        // Starvation: data re-requests back to back; fetch is masked only in
        // d_valid cycles so the data side can win STARVE_MAX times running.
        do_reset();
        grant_log.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_funct3 = 3'b000;
        if_req = 1'b1; if_addr = 8'h40;
        for (int i = 0; i < 200 && grant_log.size() < 10; i++) begin
            cycle();
            if_req = !d_valid;
        end
        check("starve_grants", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_g = (i % 5 == 4) ? {1'b0, 8'h40} : {1'b0, 8'h20};
            if (i < grant_log.size()) check($sformatf("starve_grant%0d", i), 32'(grant_log[i]), 32'(exp_g));
        end
        d_req = 1'b0; if_req = 1'b0;
        repeat (6) cycle();

        // Slow memory: ack five cycles after mem_req first rises.
        ack_delay = 5;
        if_req = 1'b1; if_addr = 8'h84;
        wait_valid(1'b1, 30, lat);
        check("slow_latency", 32'(lat), 32'd7);
        if_req = 1'b0;
        ack_delay = 0;
        cycle();

        // Reset in the middle of a data access, with ack during reset and a
        // stray ack afterwards.
        ack_delay = 100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; d_funct3 = 3'b100;
        cycle();
        cycle();
        check("mid_in_data", 32'(mem_req), 32'd1);
        rst = 1'b1; d_req = 1'b0; mem_ack = 1'b1;
        cycle();
        check("mid_rst_idle", 32'(mem_req), 32'd0);
        rst = 1'b0; mem_ack = 1'b1;
        cycle();
        check("mid_no_dvalid", 32'(d_valid), 32'd0);
        mem_ack = 1'b0;
        cycle();
        check("mid_late_ack", 32'(d_valid | mem_req), 32'd0);
        ack_delay = 0;

        // Held request: no re-grant in the valid cycle, re-grant right after.
        if_req = 1'b1; if_addr = 8'h0C;
        wait_valid(1'b1, 20, lat);
        cycle();
        check("held_no_dup", 32'(mem_req), 32'd0);
        cycle();
        check("held_regrant", 32'(mem_req), 32'd1);
        wait_valid(1'b1, 20, lat);
        if_req = 1'b0;
        cycle();

        // Randomized traffic.
        rand_delay = 1'b1;
        spurious = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            cycle();
            rst = ($urandom_range(0, 299) == 0);
            if (!if_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    if_req = 1'b1;
                    if_addr = ADDR_W'($urandom());
                end
            end else if (if_valid) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = ADDR_W'($urandom());
            end else if ($urandom_range(0, 3) == 0) begin
                if_addr = ADDR_W'($urandom());
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1;
                    scramble_d();
                end
            end else if (d_valid) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else scramble_d();
            end else if ($urandom_range(0, 3) == 0) begin
                scramble_d();
            end
        end
        rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; spurious = 1'b0;
        repeat (10) cycle();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: byte-address width shared by both requesters and the memory port.
REQ-002 SHALL have parameter STARVE_MAX, default 4: number of consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port if_req, input, 1: fetch request, held until if_valid.
REQ-006 SHALL have port if_addr, input, ADDR_W: fetch byte address.
REQ-007 SHALL have port if_rdata, output, 32: fetched instruction.
REQ-008 SHALL have port if_valid, output, 1: one-cycle fetch-complete pulse.
REQ-009 SHALL have port if_stall, output, 1: fetch pending; equals if_req & ~if_valid.
REQ-010 SHALL have port d_req, input, 1: data request, held until d_valid.
REQ-011 SHALL have port d_we, input, 1: data request is a store.
REQ-012 SHALL have port d_addr, input, ADDR_W: data byte address.
REQ-013 SHALL have port d_wdata, input, 32: store data.
REQ-014 SHALL have port d_funct3, input, 3: access size/sign, passed through unchanged.
REQ-015 SHALL have port d_rdata, output, 32: load result.
REQ-016 SHALL have port d_valid, output, 1: one-cycle data-complete pulse, for loads and stores.
REQ-017 SHALL have port d_stall, output, 1: data pending; equals d_req & ~d_valid.
REQ-018 SHALL have memory-side outputs mem_req(1), mem_we(1), mem_addr(ADDR_W), mem_wdata(32) and mem_funct3(3).
REQ-019 SHALL have memory-side inputs mem_rdata(32) and mem_ack(1); mem_ack is a one-cycle completion pulse.
REQ-020 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH and DATA.
REQ-022 SHALL, in IDLE with an eligible request, latch that request's address/we/wdata/funct3 and move to FETCH or DATA on the next edge.
REQ-023 SHALL treat a requester as ineligible in any cycle where its own valid is high, so a held req is not re-granted.
REQ-024 SHALL grant data over fetch when both are eligible, unless the starve counter equals STARVE_MAX; then fetch wins.
REQ-025 SHALL increment the starve counter on each data grant made while if_req is high, saturating at STARVE_MAX, and clear it on every fetch grant.
REQ-026 SHALL, in FETCH and DATA, drive mem_req=1 with the latched fields held stable until mem_ack.
REQ-027 SHALL drive mem_we=0 for fetches and mem_funct3=3'b010 (word) for fetches.
REQ-028 SHALL, on mem_ack in FETCH/DATA, register mem_rdata into if_rdata or d_rdata, pulse the matching valid in the next cycle and return to IDLE.
REQ-029 SHALL hold if_rdata and d_rdata between completions; d_rdata after a store is don't-care.
REQ-030 SHALL give minimum latency request-to-valid of 3 cycles: grant edge, then mem_ack in the first mem_req cycle, then valid.
REQ-031 SHALL ignore mem_ack while in IDLE.
REQ-032 SHALL ignore requester-side input changes after grant, using latched values only.
REQ-033 SHALL leave mem_addr, mem_wdata and mem_funct3 don't-care while mem_req=0, and keep mem_we=0 while mem_req=0.

Reset
REQ-034 SHALL, on rst at any edge including mid-access, go to IDLE, clear the starve counter, and set mem_req, mem_we, if_valid, d_valid and busy to 0 and if_rdata and d_rdata to 0.
REQ-035 SHALL discard a mem_ack arriving in the cycle rst is high, with no valid pulse produced.

Structure
REQ-036 SHALL place the state enum and the word funct3 constant 3'b010 in shared package mem_arb_pkg.
REQ-037 SHALL be a single module with no sub-module; grant select and starve counter are inline.

Verification
REQ-038 SHALL cover single fetch: if_req, if_addr=0x04, mem_ack one cycle after mem_req -> mem_addr=0x04, mem_we=0, if_valid 3 cycles after if_req, if_rdata=mem_rdata.
REQ-039 SHALL cover simultaneous requests: if_req and d_req with d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> store granted first with mem_we=1, d_valid pulses, then the fetch is granted.
REQ-040 SHALL cover starvation with STARVE_MAX=4: if_req held, d_req re-asserted continuously -> 4 data grants, then a fetch grant, then the counter restarts at 0.
REQ-041 SHALL cover slow memory: mem_ack delayed 5 cycles -> mem_req and latched fields stable for 5 cycles, if_stall=1 throughout, if_valid on cycle 7 after grant.
REQ-042 SHALL cover reset mid-access: rst in DATA before mem_ack -> next cycle IDLE, mem_req=0, no d_valid, and a later mem_ack is ignored.
REQ-043 SHALL cover held req: if_req kept high through the if_valid cycle -> no duplicate grant in the valid cycle; a new grant occurs in the following IDLE cycle.
